// File: rtl/uart_pkg.sv
// Shared definitions for the full-duplex UART: parity modes, FSM state
// encodings and the parity helper used by both directions.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Words narrower than 9 bits are zero-extended by the caller, which leaves
  // the XOR unchanged. Even parity is the plain XOR, odd parity its inverse.
  function automatic logic parity_of(input logic [8:0] word, input logic [1:0] mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^word);
      PAR_EVEN: p = ^word;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses tick after a full bit period, or after half a
// bit period while half is held, counting from the cycle restart drops.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal count detection and wrap back to zero on tick or restart
  always_comb begin
    tick  = !restart && (cnt_q == (half ? HALF_LAST : FULL_LAST));
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART: independent transmitter and receiver sharing only the
// clock and reset. Frame format is start, data LSB first, optional parity,
// then one or two stop bits.
module uart_duplex
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_serial,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam logic [1:0] PAR_MODE   = 2'(PARITY);
  localparam bit         HAS_PARITY = (PAR_MODE != PAR_NONE);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  // ---------------------------------------------------------------- Tx side
  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (tx_state_q == TX_IDLE),
    .half    (1'b0),
    .tick    (tx_tick)
  );

  // Tx next-state: each bit ends on a timer tick, the bit counter picks the last one
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:   if (tx_valid && tx_ready) tx_state_d = TX_START;
      TX_START:  if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:   if (tx_tick && tx_bit_q == LAST_DATA) tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_tick && tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // Tx state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  // Tx datapath: word and parity captured on accept, shifted out LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_bit_q   <= '0;
    end else begin
      if (tx_state_d != tx_state_q) begin
        tx_bit_q <= '0;
      end else if (tx_tick) begin
        tx_bit_q <= tx_bit_q + 4'd1;
      end
      if (tx_state_q == TX_IDLE && tx_valid && tx_ready) begin
        tx_shift_q <= tx_data;
        tx_par_q   <= parity_of(9'(tx_data), PAR_MODE);
      end else if (tx_state_q == TX_DATA && tx_tick) begin
        tx_shift_q <= tx_shift_q >> 1;
      end
    end
  end

  // Tx outputs decoded from state; reset forces the idle line level at once
  always_comb begin
    case (tx_state_q)
      TX_START:  tx_serial = 1'b0;
      TX_DATA:   tx_serial = tx_shift_q[0];
      TX_PARITY: tx_serial = tx_par_q;
      default:   tx_serial = 1'b1;
    endcase
    if (rst) begin
      tx_serial = 1'b1;
    end
    tx_ready = (tx_state_q == TX_IDLE) && !rst;
    tx_busy  = (tx_state_q != TX_IDLE) && !rst;
  end

  // ---------------------------------------------------------------- Rx side
  logic [1:0]           rx_sync_q;
  logic                 rx_line;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [3:0]           rx_bit_q;
  logic                 rx_ferr_acc_q;
  logic                 rx_perr_acc_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_frame_err_q;
  logic                 rx_parity_err_q;
  logic                 rx_tick;

  assign rx_line = rx_sync_q[1];

  // Two-stage synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_serial};
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk     (clk),
    .rst     (rst),
    .restart ((rx_state_q == RX_IDLE) || (rx_state_q == RX_WAIT_HIGH)),
    .half    (rx_state_q == RX_START),
    .tick    (rx_tick)
  );

  // Rx next-state: half-bit to the start centre, then one full bit per sample
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:      if (!rx_line) rx_state_d = RX_START;
      RX_START:     if (rx_tick) rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit_q == LAST_DATA) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tick) rx_state_d = RX_STOP;
      RX_STOP:      if (rx_tick && rx_bit_q == LAST_STOP) rx_state_d = rx_line ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_line) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  // Rx state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  // Rx datapath: assemble the word, accumulate errors, publish on the final stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_q      <= '0;
      rx_bit_q        <= '0;
      rx_ferr_acc_q   <= 1'b0;
      rx_perr_acc_q   <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rx_state_d != rx_state_q) begin
        rx_bit_q <= '0;
      end else if (rx_tick) begin
        rx_bit_q <= rx_bit_q + 4'd1;
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_line) begin
            rx_ferr_acc_q <= 1'b0;
            rx_perr_acc_q <= 1'b0;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift_q <= {rx_line, rx_shift_q[DATA_BITS-1:1]};
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_perr_acc_q <= (rx_line != parity_of(9'(rx_shift_q), PAR_MODE));
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_ferr_acc_q <= rx_ferr_acc_q | !rx_line;
            if (rx_bit_q == LAST_STOP) begin
              rx_valid_q      <= 1'b1;
              rx_data_q       <= rx_shift_q;
              rx_frame_err_q  <= rx_ferr_acc_q | !rx_line;
              rx_parity_err_q <= rx_perr_acc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Rx outputs, held at their reset values for every cycle reset is high
  always_comb begin
    rx_data       = rst ? '0 : rx_data_q;
    rx_valid      = rx_valid_q && !rst;
    rx_frame_err  = rx_frame_err_q && !rst;
    rx_parity_err = rx_parity_err_q && !rst;
    rx_busy       = (rx_state_q != RX_IDLE) && !rst;
  end

endmodule

// File: tb/tb_uart_duplex.sv
// Bench for uart_duplex: two instances (8N1 and 8E2, 16 clocks per bit),
// each with a switchable loopback from its own Tx line into its Rx input.
module tb_uart_duplex;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] txDataA, txDataB, rxDataA, rxDataB;
  logic txValidA, txReadyA, txBusyA, txSerialA, rxSerialA, rxValidA, rxFrameErrA, rxParityErrA, rxBusyA;
  logic txValidB, txReadyB, txBusyB, txSerialB, rxSerialB, rxValidB, rxFrameErrB, rxParityErrB, rxBusyB;
  logic loopA, loopB, rxDriveA, rxDriveB;

  assign rxSerialA = loopA ? txSerialA : rxDriveA;
  assign rxSerialB = loopB ? txSerialB : rxDriveB;

  uart_duplex #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReadyA),
    .tx_busy(txBusyA), .tx_serial(txSerialA), .rx_serial(rxSerialA), .rx_data(rxDataA),
    .rx_valid(rxValidA), .rx_frame_err(rxFrameErrA), .rx_parity_err(rxParityErrA), .rx_busy(rxBusyA)
  );

  uart_duplex #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReadyB),
    .tx_busy(txBusyB), .tx_serial(txSerialB), .rx_serial(rxSerialB), .rx_data(rxDataB),
    .rx_valid(rxValidB), .rx_frame_err(rxFrameErrB), .rx_parity_err(rxParityErrB), .rx_busy(rxBusyB)
  );

  // Received words, packed as {parity error, frame error, data}
  logic [9:0] rxQA[$];
  logic [9:0] rxQB[$];

  // Scoreboard capture of every rx_valid pulse
  always @(negedge clk) begin
    if (rxValidA) rxQA.push_back({rxParityErrA, rxFrameErrA, rxDataA});
    if (rxValidB) rxQB.push_back({rxParityErrB, rxFrameErrB, rxDataB});
  end

  // Runaway guard
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Frame length in bits: start + 8 data + parity (B only) + stop bits
  function automatic int frameLen(input bit useB);
    return useB ? 12 : 10;
  endfunction

  // Line level of bit idx of a frame carrying d; instance B uses even parity
  function automatic logic frameBit(input bit useB, input logic [7:0] d, input int idx, input bit flipPar);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (useB && idx == 9) begin
      p = ($countones(d) % 2) == 1;
      return p ^ flipPar;
    end
    return 1'b1;
  endfunction

  task automatic clearRx();
    #1;
    rxQA.delete();
    rxQB.delete();
  endtask

  task automatic checkRxCount(input bit useB, input int n);
    int size;
    #1;
    size = useB ? rxQB.size() : rxQA.size();
    checkOutput(useB ? "rxCountB" : "rxCountA", 32'(size), 32'(n));
  endtask

  task automatic expectRx(input bit useB, input logic [7:0] d, input bit fe, input bit pe);
    logic [9:0] got;
    int size;
    #1;
    size = useB ? rxQB.size() : rxQA.size();
    checkOutput("rxAvail", 32'(size > 0), 32'd1);
    if (size > 0) begin
      got = useB ? rxQB.pop_front() : rxQA.pop_front();
      checkOutput("rxData", 32'(got[7:0]), 32'(d));
      checkOutput("rxFrameErr", 32'(got[8]), 32'(fe));
      checkOutput("rxParityErr", 32'(got[9]), 32'(pe));
    end
  endtask

  // Send one word through the Tx handshake and check every line cycle
  task automatic sendTxFrame(input bit useB, input logic [7:0] d);
    int len;
    len = frameLen(useB);
    @(negedge clk);
    checkOutput("txReadyIdle", 32'(useB ? txReadyB : txReadyA), 32'd1);
    if (useB) begin txDataB = d; txValidB = 1'b1; end
    else begin txDataA = d; txValidA = 1'b1; end
    @(negedge clk);
    if (useB) begin txValidB = 1'b0; txDataB = 8'($urandom); end
    else begin txValidA = 1'b0; txDataA = 8'($urandom); end
    for (int c = 0; c < len * N; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("txSerial", 32'(useB ? txSerialB : txSerialA), 32'(frameBit(useB, d, c / N, 1'b0)));
      checkOutput("txReadyBusy", 32'(useB ? txReadyB : txReadyA), 32'd0);
      checkOutput("txBusy", 32'(useB ? txBusyB : txBusyA), 32'd1);
    end
    @(negedge clk);
    checkOutput("txReadyAfter", 32'(useB ? txReadyB : txReadyA), 32'd1);
    checkOutput("txBusyAfter", 32'(useB ? txBusyB : txBusyA), 32'd0);
    checkOutput("txLineAfter", 32'(useB ? txSerialB : txSerialA), 32'd1);
  endtask

  // Drive one frame onto an Rx input directly, optionally with a bad parity bit
  task automatic applyStimulus(input bit useB, input logic [7:0] d, input bit flipPar);
    for (int idx = 0; idx < frameLen(useB); idx++) begin
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        if (useB) rxDriveB = frameBit(useB, d, idx, flipPar);
        else rxDriveA = frameBit(useB, d, idx, flipPar);
      end
    end
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (useB) rxDriveB = 1'b1;
      else rxDriveA = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic exp;
    bit flip;

    rst = 1'b1;
    txDataA = '0; txValidA = 1'b0; txDataB = '0; txValidB = 1'b0;
    loopA = 1'b0; loopB = 1'b0; rxDriveA = 1'b1; rxDriveB = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstTxSerialA", 32'(txSerialA), 32'd1);
    checkOutput("rstTxReadyA", 32'(txReadyA), 32'd0);
    checkOutput("rstTxBusyA", 32'(txBusyA), 32'd0);
    checkOutput("rstRxDataA", 32'(rxDataA), 32'd0);
    checkOutput("rstRxValidA", 32'(rxValidA), 32'd0);
    checkOutput("rstRxFrameErrA", 32'(rxFrameErrA), 32'd0);
    checkOutput("rstRxParityErrA", 32'(rxParityErrA), 32'd0);
    checkOutput("rstRxBusyA", 32'(rxBusyA), 32'd0);
    checkOutput("rstTxSerialB", 32'(txSerialB), 32'd1);
    checkOutput("rstTxReadyB", 32'(txReadyB), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRstA", 32'(txReadyA), 32'd1);
    checkOutput("readyAfterRstB", 32'(txReadyB), 32'd1);

    // 8N1 loopback of 0xA5
    $display("[TB] 8N1 loopback");
    loopA = 1'b1;
    clearRx();
    sendTxFrame(1'b0, 8'hA5);
    checkRxCount(1'b0, 1);
    expectRx(1'b0, 8'hA5, 1'b0, 1'b0);

    // Back-to-back words with tx_valid held high
    $display("[TB] back-to-back");
    clearRx();
    @(negedge clk);
    checkOutput("b2bReadyStart", 32'(txReadyA), 32'd1);
    txDataA = 8'h00;
    txValidA = 1'b1;
    for (int t = 1; t <= 321; t++) begin
      @(negedge clk);
      if (t == 1) txDataA = 8'hFF;
      if (t <= 160) exp = frameBit(1'b0, 8'h00, (t - 1) / N, 1'b0);
      else if (t == 161) exp = 1'b1;
      else exp = frameBit(1'b0, 8'hFF, (t - 162) / N, 1'b0);
      checkOutput("b2bSerial", 32'(txSerialA), 32'(exp));
      checkOutput("b2bReady", 32'(txReadyA), 32'(t == 161));
      if (t == 162) txValidA = 1'b0;
    end
    checkRxCount(1'b0, 2);
    expectRx(1'b0, 8'h00, 1'b0, 1'b0);
    expectRx(1'b0, 8'hFF, 1'b0, 1'b0);

    // Random 8N1 loopback words
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      clearRx();
      sendTxFrame(1'b0, d);
      checkRxCount(1'b0, 1);
      expectRx(1'b0, d, 1'b0, 1'b0);
    end

    // 8E2: clean loopback, then an injected parity error
    $display("[TB] 8E2 parity");
    loopB = 1'b1;
    clearRx();
    sendTxFrame(1'b1, 8'h07);
    checkRxCount(1'b1, 1);
    expectRx(1'b1, 8'h07, 1'b0, 1'b0);
    loopB = 1'b0;
    clearRx();
    applyStimulus(1'b1, 8'h07, 1'b1);
    checkRxCount(1'b1, 1);
    expectRx(1'b1, 8'h07, 1'b0, 1'b1);

    // Random 8E2 traffic in both directions
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      loopB = 1'b1;
      clearRx();
      sendTxFrame(1'b1, d);
      expectRx(1'b1, d, 1'b0, 1'b0);
      loopB = 1'b0;
      d = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      clearRx();
      applyStimulus(1'b1, d, flip);
      checkRxCount(1'b1, 1);
      expectRx(1'b1, d, 1'b0, flip);
    end

    // Glitch shorter than half a bit on the 8N1 receiver
    $display("[TB] glitch");
    loopA = 1'b0;
    clearRx();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rxDriveA = 1'b0;
    end
    checkOutput("glitchBusy", 32'(rxBusyA), 32'd1);
    @(negedge clk);
    rxDriveA = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!rxBusyA) break;
      @(negedge clk);
    end
    checkOutput("glitchBusyCleared", 32'(rxBusyA), 32'd0);
    repeat (3 * N) @(negedge clk);
    checkRxCount(1'b0, 0);

    // Break: line low for 20 bit times
    $display("[TB] break");
    clearRx();
    for (int k = 0; k < 20 * N; k++) begin
      @(negedge clk);
      rxDriveA = 1'b0;
    end
    checkRxCount(1'b0, 1);
    expectRx(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("breakBusy", 32'(rxBusyA), 32'd1);
    @(negedge clk);
    rxDriveA = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("breakReleased", 32'(rxBusyA), 32'd0);
    checkRxCount(1'b0, 0);
    d = 8'($urandom);
    applyStimulus(1'b0, d, 1'b0);
    checkRxCount(1'b0, 1);
    expectRx(1'b0, d, 1'b0, 1'b0);

    // Reset in the middle of Tx data bit 3 with the receiver mid-frame
    $display("[TB] mid-frame reset");
    loopA = 1'b1;
    clearRx();
    d = 8'($urandom);
    @(negedge clk);
    txDataA = d;
    txValidA = 1'b1;
    @(negedge clk);
    txValidA = 1'b0;
    repeat (72) @(negedge clk);
    checkOutput("midBit3", 32'(txSerialA), 32'(d[3]));
    checkOutput("midRxBusy", 32'(rxBusyA), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("inRstTxSerial", 32'(txSerialA), 32'd1);
    checkOutput("inRstTxReady", 32'(txReadyA), 32'd0);
    checkOutput("inRstTxBusy", 32'(txBusyA), 32'd0);
    checkOutput("inRstRxBusy", 32'(rxBusyA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRstTxSerial", 32'(txSerialA), 32'd1);
    checkOutput("postRstTxBusy", 32'(txBusyA), 32'd0);
    checkOutput("postRstTxReady", 32'(txReadyA), 32'd1);
    checkOutput("postRstRxBusy", 32'(rxBusyA), 32'd0);
    checkOutput("postRstRxValid", 32'(rxValidA), 32'd0);
    checkOutput("postRstRxData", 32'(rxDataA), 32'd0);
    checkRxCount(1'b0, 0);
    sendTxFrame(1'b0, 8'h3C);
    checkRxCount(1'b0, 1);
    expectRx(1'b0, 8'h3C, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
